mem_ctrl: RTL

//  Arbitrates one byte-wide, single-port RAM between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl_ibuf.sv | 42 ++++
 rtl/mem_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller:
// FSM state encodings, mem_len encodings and the zero word.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IF_RD  = 2'd1;
    localparam logic [1:0] ST_MEM_RD = 2'd2;
    localparam logic [1:0] ST_MEM_WR = 2'd3;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Index of the final byte of a load/store; the unused 2'b10 code
    // behaves as a full word.
    function automatic logic [1:0] lastByteIndex(input logic [1:0] len);
        case (len)
            LEN_B:   return 2'd0;
            LEN_H:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ibuf.sv
// One-entry instruction fetch buffer: holds the last fetched word with its
// word tag. A store touching the buffered word drops the entry.
module mem_ctrl_ibuf
    import mem_ctrl_pkg::*;
#(
    parameter int TAG_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookupTag_i,
    output logic             hit_o,
    output logic [31:0]      data_o,
    input  logic             fillEn_i,
    input  logic [TAG_W-1:0] fillTag_i,
    input  logic [31:0]      fillData_i,
    input  logic             invalEn_i,
    input  logic [TAG_W-1:0] invalTag_i
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      data_q;

    // Entry update: a fill wins, otherwise an overlapping store clears valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= ZeroWord;
        end else if (fillEn_i) begin
            valid_q <= 1'b1;
            tag_q   <= fillTag_i;
            data_q  <= fillData_i;
        end else if (invalEn_i && (invalTag_i == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookupTag_i);
    assign data_o = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter for a single-port byte RAM shared by instruction
// fetch and load/store. Words are assembled/split little-endian and each
// finished transaction produces a one-cycle done pulse.
// Optional feature: define MEM_CTRL_IBUF_EN to add a one-entry fetch buffer
// that answers repeat fetches of the same word without touching the RAM.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [31:0]       word_q, word_d;
    logic [23:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [7:0]        ramDout_q, ramDout_d;
    logic              ramWr_q, ramWr_d;
    logic              ifDone_q, ifDone_d;
    logic              memDone_q, memDone_d;
    logic [31:0]       ifInst_q, ifInst_d;
    logic [31:0]       memRdata_q, memRdata_d;

    logic              bubble;
    logic              lastByte;
    logic [31:0]       wordIn;
    logic              ibufHit;
    logic [31:0]       ibufData;
    logic              unusedAddrBits;

    assign bubble         = ifDone_q | memDone_q;
    assign lastByte       = (cnt_q == last_q);
    assign unusedAddrBits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    // Current assembly word with the byte arriving this cycle merged in
    always_comb begin
        wordIn = word_q;
        wordIn[{cnt_q, 3'b000} +: 8] = ram_din;
    end

`ifdef MEM_CTRL_IBUF_EN
    logic fillEn;

    assign fillEn = (state_q == ST_IF_RD) && !if_flush && lastByte;

    mem_ctrl_ibuf #(
        .TAG_W(ADDR_W - 2)
    ) uIbuf (
        .clk        (clk),
        .rst        (rst),
        .lookupTag_i(if_addr[ADDR_W-1:2]),
        .hit_o      (ibufHit),
        .data_o     (ibufData),
        .fillEn_i   (fillEn),
        .fillTag_i  (ramAddr_q[ADDR_W-1:2]),
        .fillData_i (wordIn),
        .invalEn_i  (ramWr_q),
        .invalTag_i (ramAddr_q[ADDR_W-1:2])
    );
`else
    assign ibufHit  = 1'b0;
    assign ibufData = ZeroWord;
`endif

    // Next-state logic: arbitration in IDLE, then one RAM byte per cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        ramAddr_d  = ramAddr_q;
        ramDout_d  = ramDout_q;
        ramWr_d    = 1'b0;
        ifDone_d   = 1'b0;
        memDone_d  = 1'b0;
        ifInst_d   = ifInst_q;
        memRdata_d = memRdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!bubble) begin
                    if (mem_req) begin
                        cnt_d     = 2'd0;
                        last_d    = lastByteIndex(mem_len);
                        word_d    = ZeroWord;
                        ramAddr_d = mem_addr[ADDR_W-1:0];
                        if (mem_we) begin
                            state_d   = ST_MEM_WR;
                            ramWr_d   = 1'b1;
                            ramDout_d = mem_wdata[7:0];
                            wdata_d   = mem_wdata[31:8];
                        end else begin
                            state_d = ST_MEM_RD;
                        end
                    end else if (if_req && !if_flush) begin
                        if (ibufHit) begin
                            ifDone_d = 1'b1;
                            ifInst_d = ibufData;
                        end else begin
                            state_d   = ST_IF_RD;
                            cnt_d     = 2'd0;
                            last_d    = 2'd3;
                            word_d    = ZeroWord;
                            ramAddr_d = if_addr[ADDR_W-1:0];
                        end
                    end
                end
            end
            ST_IF_RD: begin
                if (if_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    word_d = wordIn;
                    if (lastByte) begin
                        state_d  = ST_IDLE;
                        ifDone_d = 1'b1;
                        ifInst_d = wordIn;
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        ramAddr_d = ramAddr_q + ADDR_W'(1);
                    end
                end
            end
            ST_MEM_RD: begin
                word_d = wordIn;
                if (lastByte) begin
                    state_d    = ST_IDLE;
                    memDone_d  = 1'b1;
                    memRdata_d = wordIn;
                end else begin
                    cnt_d     = cnt_q + 2'd1;
                    ramAddr_d = ramAddr_q + ADDR_W'(1);
                end
            end
            ST_MEM_WR: begin
                if (lastByte) begin
                    state_d   = ST_IDLE;
                    memDone_d = 1'b1;
                end else begin
                    ramWr_d   = 1'b1;
                    cnt_d     = cnt_q + 2'd1;
                    ramAddr_d = ramAddr_q + ADDR_W'(1);
                    ramDout_d = wdata_q[7:0];
                    wdata_d   = {8'h00, wdata_q[23:8]};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            word_q     <= ZeroWord;
            wdata_q    <= '0;
            ramAddr_q  <= '0;
            ramDout_q  <= 8'h00;
            ramWr_q    <= 1'b0;
            ifDone_q   <= 1'b0;
            memDone_q  <= 1'b0;
            ifInst_q   <= ZeroWord;
            memRdata_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            ramAddr_q  <= ramAddr_d;
            ramDout_q  <= ramDout_d;
            ramWr_q    <= ramWr_d;
            ifDone_q   <= ifDone_d;
            memDone_q  <= memDone_d;
            ifInst_q   <= ifInst_d;
            memRdata_q <= memRdata_d;
        end
    end

    assign if_done   = ifDone_q;
    assign if_inst   = ifInst_q;
    assign mem_done  = memDone_q;
    assign mem_rdata = memRdata_q;
    assign ram_addr  = ramAddr_q;
    assign ram_dout  = ramDout_q;
    assign ram_wr    = ramWr_q;

endmodule
